// File: rtl/lc3_chk_pkg.sv
// Shared types and constants for the LC-3 bus checker: FSM states, violation
// codes and the architectural reset value of the condition flags.
package lc3_chk_pkg;

    typedef enum logic [1:0] {
        RST_CHK = 2'd0,
        ARMED   = 2'd1,
        FAULT   = 2'd2
    } chk_state_e;

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_CONTEND = 3'd1;
    localparam logic [2:0] CODE_RESET   = 3'd2;
    localparam logic [2:0] CODE_FLAGS   = 3'd3;
    localparam logic [2:0] CODE_FLOAT   = 3'd4;

    localparam logic [2:0] NZP_RESET = 3'b010;

    // hits[i] corresponds to violation code i+1; the lowest code wins.
    function automatic logic [2:0] lowest_code(input logic [3:0] hits);
        if (hits[0]) begin
            return CODE_CONTEND;
        end else if (hits[1]) begin
            return CODE_RESET;
        end else if (hits[2]) begin
            return CODE_FLAGS;
        end else if (hits[3]) begin
            return CODE_FLOAT;
        end
        return CODE_NONE;
    endfunction

endpackage

// File: rtl/lc3_sat_counter.sv
// Up-counter with enable and synchronous clear; with SAT set it holds at
// all-ones, otherwise it wraps naturally.
module lc3_sat_counter #(
    parameter int W   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;
    logic         w_at_max;

    assign w_at_max = SAT && (&r_cnt);
    assign o_cnt    = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_at_max) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lc3_bus_checker.sv
// Run-time checker for the LC-3 datapath: flags bus contention, bad reset
// state, malformed NZP updates and floating bus reads, and logs the first fault.
module lc3_bus_checker
    import lc3_chk_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               NUM_DRV     = 4,
    parameter int               NUM_LD      = 5,
    parameter int               CNT_W       = 8,
    parameter int               STAMP_W     = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter bit               HALT_ON_ERR = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DRV-1:0] drv_en,
    input  logic [NUM_LD-1:0]  ld_en,
    input  logic [WIDTH-1:0]   pc_val,
    input  logic [WIDTH-1:0]   ir_val,
    input  logic [2:0]         nzp,
    input  logic               flag_we,
    input  logic               clr_err,
    output logic [3:0]         err_sticky,
    output logic               err_pulse,
    output logic [2:0]         first_code,
    output logic [STAMP_W-1:0] first_stamp,
    output logic [CNT_W-1:0]   viol_cnt,
    output logic [1:0]         state_o
);

    localparam int POP_W = $clog2(NUM_DRV + 1);

    chk_state_e         r_state;
    chk_state_e         w_next;
    logic               r_flag_we_d;
    logic [3:0]         r_sticky;
    logic               r_pulse;
    logic [2:0]         r_first_code;
    logic [STAMP_W-1:0] r_first_stamp;

    logic [POP_W-1:0]   w_drv_cnt;
    logic [3:0]         w_hit;
    logic               w_active;
    logic               w_clr;
    logic               w_viol;
    logic               w_cycle_en;
    logic [STAMP_W-1:0] w_cycle;
    logic [CNT_W-1:0]   w_viol_cnt;

    always_comb begin
        w_drv_cnt = '0;
        for (int i = 0; i < NUM_DRV; i++) begin
            w_drv_cnt = w_drv_cnt + POP_W'(drv_en[i]);
        end
    end

    // Bit i of w_hit is violation code i+1; reset-state check only in RST_CHK.
    assign w_active = (r_state == ARMED) || (r_state == FAULT);
    assign w_hit[0] = w_active && (w_drv_cnt > POP_W'(1));
    assign w_hit[1] = (r_state == RST_CHK) &&
                      ((pc_val != RESET_PC) || (nzp != NZP_RESET) || (ir_val != '0));
    assign w_hit[2] = w_active && r_flag_we_d && !$onehot(nzp);
    assign w_hit[3] = w_active && (ld_en != '0) && (drv_en == '0);

    // A clear in the same cycle as a violation swallows the violation.
    assign w_clr      = clr_err && w_active;
    assign w_viol     = (|w_hit) && !w_clr;
    assign w_cycle_en = !(HALT_ON_ERR && (r_state == FAULT));

    always_comb begin
        w_next = r_state;
        case (r_state)
            RST_CHK: w_next = w_viol ? FAULT : ARMED;
            ARMED: begin
                if (w_clr) begin
                    w_next = ARMED;
                end else if (w_viol) begin
                    w_next = FAULT;
                end
            end
            FAULT: begin
                if (w_clr) begin
                    w_next = ARMED;
                end
            end
            default: w_next = RST_CHK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RST_CHK;
            r_flag_we_d <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_flag_we_d <= flag_we;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sticky      <= '0;
            r_pulse       <= 1'b0;
            r_first_code  <= CODE_NONE;
            r_first_stamp <= '0;
        end else if (w_clr) begin
            r_sticky      <= '0;
            r_pulse       <= 1'b0;
            r_first_code  <= CODE_NONE;
            r_first_stamp <= '0;
        end else begin
            r_pulse <= w_viol;
            if (w_viol) begin
                r_sticky <= r_sticky | w_hit;
                if (r_first_code == CODE_NONE) begin
                    r_first_code  <= lowest_code(w_hit);
                    r_first_stamp <= w_cycle;
                end
            end
        end
    end

    lc3_sat_counter #(
        .W   (CNT_W),
        .SAT (1'b1)
    ) u_viol_cnt (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_viol),
        .i_clr (w_clr),
        .o_cnt (w_viol_cnt)
    );

    lc3_sat_counter #(
        .W   (STAMP_W),
        .SAT (1'b0)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst),
        .i_en  (w_cycle_en),
        .i_clr (1'b0),
        .o_cnt (w_cycle)
    );

    assign err_sticky  = r_sticky;
    assign err_pulse   = r_pulse;
    assign first_code  = r_first_code;
    assign first_stamp = r_first_stamp;
    assign viol_cnt    = w_viol_cnt;
    assign state_o     = r_state;

endmodule

// File: tb/tb_lc3_bus_checker.sv
// Scoreboard bench for lc3_bus_checker: directed vectors queue expected outputs,
// a negedge monitor pops and compares them against two differently-parametrised DUTs.
module tb_lc3_bus_checker;

    localparam logic [1:0] ST_RST   = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  drvEn = '0;
    logic [4:0]  ldEn = '0;
    logic [15:0] pcVal = '0;
    logic [15:0] irVal = '0;
    logic [2:0]  nzp = 3'b010;
    logic        flagWe = 1'b0;
    logic        clrErr = 1'b0;

    logic [3:0]  stickyA, stickyB;
    logic        pulseA, pulseB;
    logic [2:0]  codeA, codeB;
    logic [15:0] stampA, stampB;
    logic [7:0]  cntA;
    logic [1:0]  cntB;
    logic [1:0]  stateA, stateB;

    lc3_bus_checker dutA (
        .clk(clk), .rst(rst), .drv_en(drvEn), .ld_en(ldEn), .pc_val(pcVal),
        .ir_val(irVal), .nzp(nzp), .flag_we(flagWe), .clr_err(clrErr),
        .err_sticky(stickyA), .err_pulse(pulseA), .first_code(codeA),
        .first_stamp(stampA), .viol_cnt(cntA), .state_o(stateA)
    );

    // Small saturating counter and halting cycle stamp.
    lc3_bus_checker #(.CNT_W(2), .HALT_ON_ERR(1'b1)) dutB (
        .clk(clk), .rst(rst), .drv_en(drvEn), .ld_en(ldEn), .pc_val(pcVal),
        .ir_val(irVal), .nzp(nzp), .flag_we(flagWe), .clr_err(clrErr),
        .err_sticky(stickyB), .err_pulse(pulseB), .first_code(codeB),
        .first_stamp(stampB), .viol_cnt(cntB), .state_o(stateB)
    );

    always #5 clk = ~clk;

    int tbCycle = 0;
    always @(posedge clk) tbCycle <= tbCycle + 1;

    typedef struct {
        string       name;
        int          target;
        bit          dutB;
        logic [3:0]  sticky;
        logic        pulse;
        logic [2:0]  code;
        logic [15:0] stamp;
        logic [7:0]  cnt;
        logic [1:0]  st;
    } exp_t;

    exp_t expQ[$];
    exp_t monItem;
    int   testsRun = 0;
    int   testsFailed = 0;

    // Queue an expectation checked at the negedge of cycle tbCycle+lat.
    task automatic expectOut(input string name, input bit dutB, input int lat,
                             input logic [3:0] sticky, input logic pulse,
                             input logic [2:0] code, input logic [15:0] stamp,
                             input logic [7:0] cnt, input logic [1:0] st);
        exp_t e;
        e.name = name; e.target = tbCycle + lat; e.dutB = dutB;
        e.sticky = sticky; e.pulse = pulse; e.code = code;
        e.stamp = stamp; e.cnt = cnt; e.st = st;
        expQ.push_back(e);
    endtask

    task automatic exA(input string name, input logic [3:0] sticky, input logic pulse,
                       input logic [2:0] code, input logic [15:0] stamp,
                       input logic [7:0] cnt, input logic [1:0] st);
        expectOut(name, 1'b0, 1, sticky, pulse, code, stamp, cnt, st);
    endtask

    task automatic exB(input string name, input logic [3:0] sticky, input logic pulse,
                       input logic [2:0] code, input logic [15:0] stamp,
                       input logic [7:0] cnt, input logic [1:0] st);
        expectOut(name, 1'b1, 1, sticky, pulse, code, stamp, cnt, st);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [33:0] act;
        logic [33:0] want;
        if (e.dutB)
            act = {stickyB, pulseB, codeB, stampB, 6'b0, cntB, stateB};
        else
            act = {stickyA, pulseA, codeA, stampA, cntA, stateA};
        want = {e.sticky, e.pulse, e.code, e.stamp, e.cnt, e.st};
        testsRun++;
        if (act !== want) begin
            testsFailed++;
            $display("[TB] FAIL %s: got sticky=%b pulse=%b code=%0d stamp=%0d cnt=%0d state=%0d, expected sticky=%b pulse=%b code=%0d stamp=%0d cnt=%0d state=%0d",
                     e.name, act[33:30], act[29], act[28:26], act[25:10], act[9:2], act[1:0],
                     e.sticky, e.pulse, e.code, e.stamp, e.cnt, e.st);
        end
    endtask

    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].target <= tbCycle) begin
            monItem = expQ.pop_front();
            if (monItem.target < tbCycle) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL %s: check missed, now cycle %0d, expected at cycle %0d",
                         monItem.name, tbCycle, monItem.target);
            end else begin
                checkOutput(monItem);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] drv, input logic [4:0] ld,
                                 input logic [2:0] nzpV, input logic fwe, input logic clr);
        drvEn = drv; ldEn = ld; nzp = nzpV; flagWe = fwe; clrErr = clr;
    endtask

    // Assert reset mid-cycle, check both DUTs before any edge, then release;
    // on return the current inputs are those seen in RST_CHK (cycle 0).
    task automatic doReset(input string name, input logic [15:0] pcV);
        tick();
        rst = 1'b0;
        pcVal = pcV;
        irVal = '0;
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b0, 1'b0);
        #1;
        expectOut({name, "_A"}, 1'b0, 0, 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_RST);
        expectOut({name, "_B"}, 1'b1, 0, 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_RST);
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL timeout: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Clean reset followed by legal traffic.
        doReset("reset_clean", 16'h0000);
        exA("clean_rst_chk", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        exB("clean_rst_chk_B", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        tick();
        for (int i = 1; i < 100; i++) tick();
        exA("clean_traffic", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        tick();

        // Bad PC at reset release.
        doReset("reset_bad", 16'h3000);
        exA("bad_reset", 4'b0010, 1'b1, 3'd2, 16'd0, 8'd1, ST_FAULT);
        tick();
        pcVal = 16'h0000;
        exA("bad_reset_hold", 4'b0010, 1'b0, 3'd2, 16'd0, 8'd1, ST_FAULT);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b0, 1'b1);
        exA("clear_after_bad", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        tick();

        // Contention at cycle 10 for three cycles.
        doReset("reset_contend", 16'h0000);
        for (int i = 0; i < 10; i++) tick();
        applyStimulus(4'b0101, 5'b00001, 3'b010, 1'b0, 1'b0);
        exA("contend_1", 4'b0001, 1'b1, 3'd1, 16'd10, 8'd1, ST_FAULT);
        tick();
        exA("contend_2", 4'b0001, 1'b1, 3'd1, 16'd10, 8'd2, ST_FAULT);
        tick();
        exA("contend_3", 4'b0001, 1'b1, 3'd1, 16'd10, 8'd3, ST_FAULT);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b0, 1'b0);
        exA("contend_end", 4'b0001, 1'b0, 3'd1, 16'd10, 8'd3, ST_FAULT);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b0, 1'b1);
        tick();

        // Flag write followed by a non-one-hot NZP (cycles 15/16).
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b1, 1'b0);
        exA("flags_we_legal", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b110, 1'b0, 1'b0);
        exA("flags_bad", 4'b0100, 1'b1, 3'd3, 16'd16, 8'd1, ST_FAULT);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b0, 1'b0);
        exA("flags_hold", 4'b0100, 1'b0, 3'd3, 16'd16, 8'd1, ST_FAULT);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b0, 1'b1);
        exA("flags_clear", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b001, 1'b0, 1'b0);
        exA("flags_ok_001", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b110, 1'b0, 1'b0);
        exA("nzp_bad_without_we", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        tick();

        // Floating read, then a floating read coinciding with clr_err.
        applyStimulus(4'b0000, 5'b00001, 3'b010, 1'b0, 1'b0);
        exA("float", 4'b1000, 1'b1, 3'd4, 16'd22, 8'd1, ST_FAULT);
        tick();
        applyStimulus(4'b0000, 5'b00001, 3'b010, 1'b0, 1'b1);
        exA("clr_wins", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b0, 1'b0);
        exA("after_clr", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        tick();

        // Two classes in one cycle count once; later faults keep first code.
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b1, 1'b0);
        tick();
        applyStimulus(4'b0101, 5'b00001, 3'b000, 1'b0, 1'b0);
        exA("multi_class", 4'b0101, 1'b1, 3'd1, 16'd26, 8'd1, ST_FAULT);
        tick();
        applyStimulus(4'b0000, 5'b00001, 3'b010, 1'b0, 1'b0);
        exA("no_overwrite", 4'b1101, 1'b1, 3'd1, 16'd26, 8'd2, ST_FAULT);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b0, 1'b0);
        exA("multi_hold", 4'b1101, 1'b0, 3'd1, 16'd26, 8'd2, ST_FAULT);
        tick();

        // Saturation at 3 and frozen cycle stamp in DUT B.
        doReset("reset_sat", 16'h0000);
        exB("b_rst_chk", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        tick();
        applyStimulus(4'b0101, 5'b00001, 3'b010, 1'b0, 1'b0);
        exB("b_viol_1", 4'b0001, 1'b1, 3'd1, 16'd1, 8'd1, ST_FAULT);
        tick();
        exB("b_viol_2", 4'b0001, 1'b1, 3'd1, 16'd1, 8'd2, ST_FAULT);
        tick();
        exB("b_viol_3", 4'b0001, 1'b1, 3'd1, 16'd1, 8'd3, ST_FAULT);
        tick();
        exB("b_sat_4", 4'b0001, 1'b1, 3'd1, 16'd1, 8'd3, ST_FAULT);
        tick();
        exB("b_sat_5", 4'b0001, 1'b1, 3'd1, 16'd1, 8'd3, ST_FAULT);
        exA("a_count_5", 4'b0001, 1'b1, 3'd1, 16'd1, 8'd5, ST_FAULT);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b0, 1'b1);
        exB("b_clear", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        exA("a_clear", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        tick();
        applyStimulus(4'b0101, 5'b00001, 3'b010, 1'b0, 1'b0);
        exB("b_frozen_stamp", 4'b0001, 1'b1, 3'd1, 16'd2, 8'd1, ST_FAULT);
        exA("a_running_stamp", 4'b0001, 1'b1, 3'd1, 16'd7, 8'd1, ST_FAULT);
        tick();
        applyStimulus(4'b0010, 5'b00001, 3'b010, 1'b0, 1'b0);

        // Mid-run reset returns everything to zero immediately.
        doReset("reset_midrun", 16'h0000);
        exA("post_reset_A", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        exB("post_reset_B", 4'b0, 1'b0, 3'd0, 16'd0, 8'd0, ST_ARMED);
        tick();
        tick();
        tick();

        while (expQ.size() > 0) begin
            monItem = expQ.pop_front();
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: check never reached, expected at cycle %0d", monItem.name, monItem.target);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
